// File: rtl/eu_writeback_if.sv
// Handshake bundle between the EU result source, the writeback stage and the register-file write port.
// The slave view belongs to eu_writeback, and the master view belongs to the environment driving it.
interface eu_writeback_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 3
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [BUS_WIDTH-1:0]  in_data;
  logic [3:0]            in_op_select;
  logic                  in_carry;
  logic [ADDR_WIDTH-1:0] in_dest;
  logic                  in_flag_en;
  logic                  wr_en;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [BUS_WIDTH-1:0]  wr_data;

  modport master (
    output in_valid, in_data, in_op_select, in_carry, in_dest, in_flag_en, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_op_select, in_carry, in_dest, in_flag_en, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/eu_writeback.sv
// EU writeback stage: a 2-entry in-order result buffer feeding the register-file write port,
// committing {C,P,N,Z} status flags and counting retired writes.
module eu_writeback #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  eu_writeback_if.slave bus,
  output logic [3:0]  flags,
  output logic [15:0] retire_count
);

  typedef enum logic {EMPTY = 1'b0, VALID = 1'b1} entry_state_t;

  entry_state_t          head_state, tail_state;
  logic [BUS_WIDTH-1:0]  head_data, tail_data;
  logic [ADDR_WIDTH-1:0] head_dest, tail_dest;
  logic                  head_flag_en, tail_flag_en;
  logic [3:0]            head_flags, tail_flags;
  logic                  in_ready_q;

  logic                  push, pop, full_next;
  logic [3:0]            new_flags;

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = (head_state == VALID);
  assign bus.wr_addr  = head_dest;
  assign bus.wr_data  = head_data;

  // Flags are computed at push time, so the commit edge only has to copy a stored value.
  always_comb begin
    push      = bus.in_valid && in_ready_q && (bus.in_op_select != 4'b0000);
    pop       = (head_state == VALID) && bus.wr_ready;
    new_flags = {(bus.in_op_select[3] ? 1'b0 : bus.in_carry),
                 ~^bus.in_data,
                 bus.in_data[BUS_WIDTH-1],
                 (bus.in_data == '0)};
    full_next = 1'b0;
    if (tail_state == VALID) begin
      full_next = !pop;
    end else if (head_state == VALID) begin
      full_next = push && !pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_state   <= EMPTY;
      tail_state   <= EMPTY;
      head_data    <= '0;
      head_dest    <= '0;
      head_flag_en <= 1'b0;
      head_flags   <= 4'b0000;
      in_ready_q   <= 1'b1;
      flags        <= 4'b0000;
      retire_count <= 16'd0;
    end else begin
      in_ready_q <= !full_next;

      if (pop) begin
        retire_count <= retire_count + 16'd1;
        if (head_flag_en) begin
          flags <= head_flags;
        end
      end

      // A push is impossible while the tail is valid, because in_ready is low at occupancy 2.
      if (pop) begin
        if (tail_state == VALID) begin
          head_data    <= tail_data;
          head_dest    <= tail_dest;
          head_flag_en <= tail_flag_en;
          head_flags   <= tail_flags;
          tail_state   <= EMPTY;
        end else if (push) begin
          head_data    <= bus.in_data;
          head_dest    <= bus.in_dest;
          head_flag_en <= bus.in_flag_en;
          head_flags   <= new_flags;
        end else begin
          head_state   <= EMPTY;
        end
      end else if (push) begin
        if (head_state == EMPTY) begin
          head_state   <= VALID;
          head_data    <= bus.in_data;
          head_dest    <= bus.in_dest;
          head_flag_en <= bus.in_flag_en;
          head_flags   <= new_flags;
        end else begin
          tail_state   <= VALID;
          tail_data    <= bus.in_data;
          tail_dest    <= bus.in_dest;
          tail_flag_en <= bus.in_flag_en;
          tail_flags   <= new_flags;
        end
      end
    end
  end

endmodule

// File: doc/eu_writeback.md
Name: eu_writeback

Overview:
- Execution-unit writeback stage. It sits directly downstream of the EU logic/arithmetic datapath.
- Captures each EU result with its destination register index in a 2-entry buffer.
- Presents results in order to the register-file write port using a valid/ready handshake.
- Updates the processor status flags (Z, N, P, C) when each result commits.

Parameters:
- BUS_WIDTH, 16, datapath width of results and register-file write data.
- ADDR_WIDTH, 3, width of the destination register index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  EU result valid this cycle.
- in_ready  output  1  stage can accept a result this cycle.
- in_data  input  BUS_WIDTH  EU result (EU data_out).
- in_op_select  input  4  op_select that produced in_data.
- in_carry  input  1  carry out from the arithmetic path; ignored for logic ops.
- in_dest  input  ADDR_WIDTH  destination register index.
- in_flag_en  input  1  result updates flags when it commits.
- wr_en  output  1  register-file write request.
- wr_ready  input  1  register file accepts the write this cycle.
- wr_addr  output  ADDR_WIDTH  write address.
- wr_data  output  BUS_WIDTH  write data.
- flags  output  4  {C,P,N,Z} committed status flags.
- retire_count  output  16  count of committed writes; wraps.

Behaviour:
- Reset (rst_n=0 at a clock edge): buffer emptied, wr_en=0, wr_addr=0, wr_data=0, flags=4'b0000, retire_count=0, in_ready=1 from the next cycle. Reset mid-operation discards buffered results without writing them.
- Buffer: 2-entry in-order FIFO. Each entry holds data, dest, flag_en, and the precomputed flags.
- in_ready = (occupancy < 2). It is a registered function of occupancy only and has no combinational path from wr_ready.
- Push: a push occurs when in_valid && in_ready && in_op_select != 4'b0000.
- NOP: in_op_select == 4'b0000 with in_valid=1 is accepted and dropped. Nothing is stored or written, and flags and the counter are unchanged.
- Output: wr_en=1 whenever the head entry is valid. wr_addr and wr_data come from the head entry and are driven from registers. They are stable while wr_en=1 && wr_ready=0.
- Pop/commit: a commit occurs on an edge where wr_en && wr_ready. The head is popped and retire_count increments by 1 (0xFFFF wraps to 0x0000). If the head's flag_en=1, flags load the head's flags at the same edge. If flag_en=0, flags hold.
- Latency: a result pushed at edge N appears on wr_en/wr_data during cycle N+1 when the buffer was empty. With wr_ready=1, it commits at edge N+1, and flags are visible in cycle N+2.
- Simultaneous push and pop: allowed at occupancy 1 (occupancy stays 1, order preserved). At occupancy 0 the push is not visible at the output until the next cycle, so no bypass is needed.
- Full (occupancy 2): in_ready=0 and in_valid is ignored. in_ready returns to 1 in the cycle after a pop.
- Flag computation, at push, from in_data:
  - Z = (in_data == 0).
  - N = in_data[BUS_WIDTH-1].
  - P = 1 when in_data has an even number of ones (XNOR-reduce).
  - C = in_op_select[3] ? 0 : in_carry. Logic ops (1xxx) always clear C.
- States per entry: EMPTY, VALID. Occupancy transitions between 0, 1 and 2 only, driven by push and pop. No other states exist.
- Back-to-back: sustained throughput is 1 result per cycle while wr_ready=1.

Test Plan:
- Reset, then op 1000, in_data=0xCAFE, dest=3, flag_en=1, wr_ready=1 -> cycle+1: wr_en=1, wr_addr=3, wr_data=0xCAFE. Next cycle: flags={C0,P0,N1,Z0}, retire_count=1.
- op 1010, in_data=0x0000, flag_en=1, then op 1011, in_data=0x00EE, flag_en=0 -> both written in order. flags={0,1,0,1} after the first commit and unchanged after the second.
- wr_ready=0; push results 0x1111, 0x2222, 0x3333 on consecutive cycles -> first two accepted, in_ready=0 from the third cycle, wr_data held at 0x1111. Raise wr_ready -> writes 0x1111, 0x2222 in order. 0x3333 is accepted once in_ready=1 and written afterward.
- in_valid=1, op 0000, in_data=0xFFFF -> no wr_en, flags and retire_count unchanged, in_ready stays 1.
- Arithmetic op 0001, in_data=0x8000, in_carry=1, flag_en=1 -> flags={C1,P0,N1,Z0}.
- Two entries buffered with wr_ready=0, then rst_n=0 for one cycle -> wr_en=0, flags=0, retire_count=0. The discarded results never appear on the write port.
